// File: rtl/ex_mc.sv
// ex_mc -- execute stage with single-cycle ALU ops and a multi-cycle divider
//
// Purpose:
//   Computes logic, shift and add/sub results combinationally. DIV/DIVU run on
//   a radix-2 restoring divider that retires one quotient bit per cycle. The
//   stage holds the upstream pipeline through stall_req_o while dividing and
//   pulses whilo_o for one cycle with the remainder on hi_o and the quotient
//   on lo_o.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   aluop_i      in   operation code
//   alusel_i     in   result group select (001 logic, 010 shift, 100 arith)
//   reg1_i       in   operand 1 / dividend / shift amount
//   reg2_i       in   operand 2 / divisor / value to shift
//   wd_i         in   destination register address
//   wreg_i       in   destination write enable
//   annul_i      in   flush, aborts an in-flight divide
//   wd_o         out  destination register address (pass-through)
//   wreg_o       out  destination write enable (pass-through)
//   wdata_o      out  GPR write data
//   whilo_o      out  HI/LO write enable, one cycle at divide completion
//   hi_o         out  remainder (valid only while whilo_o is high)
//   lo_o         out  quotient (valid only while whilo_o is high)
//   stall_req_o  out  hold upstream pipeline while dividing
module ex_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       aluop_i,
  input  logic [2:0]       alusel_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  input  logic             annul_i,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall_req_o
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_negQ;
  logic             r_negR;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_isDiv;
  logic             w_start;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_diff;
  logic             w_qBit;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quotNext;
  logic [WIDTH-1:0] w_quotFix;
  logic [WIDTH-1:0] w_remFix;
  logic             w_valid;
  logic [WIDTH-1:0] w_result;
  logic [SH_W-1:0]  w_shamt;

  // Divide issue decode; annul blocks a start from IDLE.
  assign w_isDiv = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign w_start = (r_state == S_IDLE) && w_isDiv && !annul_i;

  // Signed mode divides magnitudes; the most negative value's magnitude is
  // still correct when read back as unsigned.
  assign w_neg1 = (aluop_i == OP_DIV) && reg1_i[WIDTH-1];
  assign w_neg2 = (aluop_i == OP_DIV) && reg2_i[WIDTH-1];
  assign w_abs1 = w_neg1 ? -reg1_i : reg1_i;
  assign w_abs2 = w_neg2 ? -reg2_i : reg2_i;

  // One restoring step: shift in the next dividend bit, trial-subtract with an
  // extra bit so a partial remainder up to 2*divisor-1 cannot overflow.
  assign w_partial  = {r_rem, r_dividend[WIDTH-1]};
  assign w_diff     = w_partial - {1'b0, r_divisor};
  assign w_qBit     = ~w_diff[WIDTH];
  assign w_remNext  = w_qBit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
  assign w_quotNext = {r_quot[WIDTH-2:0], w_qBit};
  assign w_quotFix  = r_negQ ? -w_quotNext : w_quotNext;
  assign w_remFix   = r_negR ? -w_remNext : w_remNext;

  // Divider FSM: operands latched at issue, result registered on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dividend <= w_abs1;
            r_divisor  <= w_abs2;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_negQ     <= w_neg1 ^ w_neg2;
            r_negR     <= w_neg1;
            if (reg2_i == '0) begin
              r_hi    <= reg1_i;
              r_lo    <= '1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_rem      <= w_remNext;
            r_quot     <= w_quotNext;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_hi    <= w_remFix;
              r_lo    <= w_quotFix;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Single-cycle result: the op must belong to the group chosen by alusel_i,
  // anything else yields zero.
  assign w_shamt = reg1_i[SH_W-1:0];

  always_comb begin
    w_result = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  w_result = reg1_i & reg2_i;
          OP_OR:   w_result = reg1_i | reg2_i;
          OP_XOR:  w_result = reg1_i ^ reg2_i;
          OP_NOR:  w_result = ~(reg1_i | reg2_i);
          default: w_result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  w_result = reg2_i << w_shamt;
          OP_SRL:  w_result = reg2_i >> w_shamt;
          OP_SRA:  w_result = $signed(reg2_i) >>> w_shamt;
          default: w_result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADDU: w_result = reg1_i + reg2_i;
          OP_SUBU: w_result = reg1_i - reg2_i;
          default: w_result = '0;
        endcase
      end
      default: w_result = '0;
    endcase
  end

  // Outputs are forced to zero while reset is asserted; an annul in DONE
  // suppresses the HI/LO write.
  assign w_valid     = (r_state == S_DONE) && !annul_i;
  assign whilo_o     = rst && w_valid;
  assign hi_o        = (rst && w_valid) ? r_hi : '0;
  assign lo_o        = (rst && w_valid) ? r_lo : '0;
  assign stall_req_o = rst && (w_start || ((r_state == S_BUSY) && !annul_i));
  assign wdata_o     = (rst && (r_state == S_IDLE) && !w_start) ? w_result : '0;
  assign wd_o        = rst ? wd_i : 5'd0;
  assign wreg_o      = rst && wreg_i;

endmodule

// File: tb/tb_ex_mc.sv
// tb_ex_mc -- self-checking bench for ex_mc (WIDTH=32)
//
// Directed cases for the ALU and divider corner cases, then randomized ALU
// ops and divides compared against a plain-arithmetic reference model.
module tb_ex_mc;

  localparam int WIDTH = 32;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_NOP  = 8'h00;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       aluop_i;
  logic [2:0]       alusel_i;
  logic [WIDTH-1:0] reg1_i;
  logic [WIDTH-1:0] reg2_i;
  logic [4:0]       wd_i;
  logic             wreg_i;
  logic             annul_i;
  logic [4:0]       wd_o;
  logic             wreg_o;
  logic [WIDTH-1:0] wdata_o;
  logic             whilo_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             stall_req_o;

  int errorCount = 0;
  int checkCount = 0;

  ex_mc #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .annul_i     (annul_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .stall_req_o (stall_req_o)
  );

  // 10 ns free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive a new input set on the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic annul);
    @(negedge clk);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    annul_i  = annul;
    #1;
  endtask

  // Reference for single-cycle ops: the op has to belong to the selected group.
  function automatic logic [WIDTH-1:0] expectAlu(input logic [7:0] op, input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(a % WIDTH);
    if (sel == 3'b001) begin
      if (op == OP_AND) return a & b;
      if (op == OP_OR)  return a | b;
      if (op == OP_XOR) return a ^ b;
      if (op == OP_NOR) return ~(a | b);
    end else if (sel == 3'b010) begin
      if (op == OP_SLL) return b << sh;
      if (op == OP_SRL) return b >> sh;
      if (op == OP_SRA) return WIDTH'($signed(b) >>> sh);
    end else if (sel == 3'b100) begin
      if (op == OP_ADDU) return a + b;
      if (op == OP_SUBU) return a - b;
    end
    return '0;
  endfunction

  // Reference divide in 64-bit arithmetic: truncating division, remainder
  // follows the dividend; MIN/-1 wraps naturally once truncated to WIDTH bits.
  task automatic expectDiv(input logic [7:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b,
                           output logic [WIDTH-1:0] hiE, output logic [WIDTH-1:0] loE);
    longint sa, sb, q, r;
    if (b == 0) begin
      loE = '1;
      hiE = a;
    end else if (op == OP_DIV) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      loE = WIDTH'(q);
      hiE = WIDTH'(r);
    end else begin
      loE = a / b;
      hiE = a % b;
    end
  endtask

  // Issue one divide and follow it to completion within a bounded window.
  task automatic runDivide(input logic [7:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input string tag);
    logic [WIDTH-1:0] hiE, loE;
    int stallCycles;
    bit seenDone;
    expectDiv(op, a, b, hiE, loE);
    applyStimulus(op, 3'b000, a, b, 1'b0);
    checkOutput({tag, "-issueStall"}, WIDTH'(stall_req_o), 1);
    checkOutput({tag, "-issueWhilo"}, WIDTH'(whilo_o), 0);
    checkOutput({tag, "-issueWdata"}, wdata_o, 0);
    stallCycles = 1;
    seenDone = 1'b0;
    for (int c = 0; c < WIDTH + 4 && !seenDone; c++) begin
      @(negedge clk);
      #1;
      if (whilo_o) begin
        seenDone = 1'b1;
        checkOutput({tag, "-lo"}, lo_o, loE);
        checkOutput({tag, "-hi"}, hi_o, hiE);
        checkOutput({tag, "-doneStall"}, WIDTH'(stall_req_o), 0);
        checkOutput({tag, "-stallCycles"}, WIDTH'(stallCycles), (b == 0) ? 1 : WIDTH + 1);
      end else if (stall_req_o) begin
        stallCycles++;
      end
    end
    if (!seenDone) checkOutput({tag, "-timeout"}, 0, 1);
  endtask

  // Watch a window of idle cycles and flag any HI/LO write or stall.
  task automatic checkQuiet(input string tag, input int cycles);
    int pulses;
    int stalls;
    pulses = 0;
    stalls = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      if (whilo_o) pulses++;
      if (stall_req_o) stalls++;
    end
    checkOutput({tag, "-whiloPulses"}, WIDTH'(pulses), 0);
    checkOutput({tag, "-stalls"}, WIDTH'(stalls), 0);
  endtask

  // Main sequence: reset, directed ALU, directed divides, annul/reset aborts,
  // then randomized traffic.
  initial begin
    logic [7:0] opList [12];
    logic [2:0] selList [6];
    logic [7:0] op;
    logic [2:0] sel;
    logic [WIDTH-1:0] a, b;

    opList  = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                OP_ADDU, OP_SUBU, OP_NOP, 8'h55, 8'hFF};
    selList = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b011, 3'b111};

    rst      = 1'b0;
    aluop_i  = OP_DIV;
    alusel_i = 3'b100;
    reg1_i   = 32'd5;
    reg2_i   = 32'd3;
    wd_i     = 5'h1F;
    wreg_i   = 1'b1;
    annul_i  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstStall", WIDTH'(stall_req_o), 0);
    checkOutput("rstWhilo", WIDTH'(whilo_o), 0);
    checkOutput("rstHi", hi_o, 0);
    checkOutput("rstLo", lo_o, 0);
    checkOutput("rstWdata", wdata_o, 0);
    checkOutput("rstWreg", WIDTH'(wreg_o), 0);
    @(negedge clk);
    aluop_i = OP_NOP;
    rst = 1'b1;

    applyStimulus(OP_OR, 3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b0);
    checkOutput("or", wdata_o, 32'hFFFF_00FF);
    checkOutput("orWd", WIDTH'(wd_o), 32'h1F);
    applyStimulus(OP_AND, 3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b0);
    checkOutput("and", wdata_o, 32'h0000_0000);
    applyStimulus(OP_NOR, 3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b0);
    checkOutput("nor", wdata_o, 32'h0000_FF00);
    applyStimulus(OP_ADDU, 3'b100, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b0);
    checkOutput("addu", wdata_o, 32'hFFFF_00FF);
    applyStimulus(OP_SUBU, 3'b100, 32'hF0F0_0000, 32'h0F0F_00FF, 1'b0);
    checkOutput("subu", wdata_o, 32'hE1E0_FF01);
    applyStimulus(OP_SRA, 3'b010, 32'd4, 32'h8000_0000, 1'b0);
    checkOutput("sra", wdata_o, 32'hF800_0000);
    applyStimulus(OP_SLL, 3'b010, 32'd4, 32'h8000_0000, 1'b0);
    checkOutput("sll", wdata_o, 32'h0000_0000);
    applyStimulus(OP_SRL, 3'b010, 32'd4, 32'h8000_0000, 1'b0);
    checkOutput("srl", wdata_o, 32'h0800_0000);
    applyStimulus(OP_ADDU, 3'b001, 32'h1234, 32'h1, 1'b0);
    checkOutput("selMismatch", wdata_o, 32'h0);

    runDivide(OP_DIVU, 32'd100, 32'd7, "divu100by7");
    runDivide(OP_DIV, 32'hFFFF_FFF9, 32'd2, "divNeg7by2");
    runDivide(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divMinByM1");
    runDivide(OP_DIVU, 32'd5, 32'd0, "divu5by0");
    runDivide(OP_DIV, 32'hFFFF_FFF0, 32'd0, "divNegBy0");
    runDivide(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, "backToBack");
    applyStimulus(OP_NOP, 3'b000, 32'd0, 32'd0, 1'b0);
    checkOutput("pulseOnceWhilo", WIDTH'(whilo_o), 0);
    checkOutput("pulseOnceLo", lo_o, 0);

    // Annul in IDLE must block the start entirely.
    applyStimulus(OP_DIVU, 3'b000, 32'd50, 32'd3, 1'b1);
    checkOutput("annulIdleStall", WIDTH'(stall_req_o), 0);
    applyStimulus(OP_NOP, 3'b000, 32'd0, 32'd0, 1'b0);
    checkQuiet("annulIdle", 40);

    // Annul in the tenth BUSY cycle: stall drops at once, no HI/LO write.
    applyStimulus(OP_DIVU, 3'b000, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    applyStimulus(OP_DIVU, 3'b000, 32'd1000, 32'd3, 1'b1);
    checkOutput("annulBusyStall", WIDTH'(stall_req_o), 0);
    checkOutput("annulBusyWhilo", WIDTH'(whilo_o), 0);
    applyStimulus(OP_NOP, 3'b000, 32'd0, 32'd0, 1'b0);
    checkQuiet("annulBusy", 40);

    // Reset in the middle of a divide: outputs drop immediately, then a fresh
    // divide must behave normally.
    applyStimulus(OP_DIV, 3'b000, 32'hFFFF_FC18, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midRstStall", WIDTH'(stall_req_o), 0);
    checkOutput("midRstWhilo", WIDTH'(whilo_o), 0);
    @(negedge clk);
    aluop_i = OP_NOP;
    rst = 1'b1;
    checkQuiet("midRst", 40);
    runDivide(OP_DIV, 32'hFFFF_FC18, 32'd7, "afterRst");

    // Randomized single-cycle ops, including unknown ops and selects.
    for (int i = 0; i < 60; i++) begin
      op  = opList[$urandom_range(0, 11)];
      sel = selList[$urandom_range(0, 5)];
      a   = $urandom;
      b   = $urandom;
      wd_i   = 5'($urandom);
      wreg_i = 1'($urandom);
      applyStimulus(op, sel, a, b, 1'b0);
      checkOutput($sformatf("rndAlu%0d-op%h-sel%b", i, op, sel), wdata_o, expectAlu(op, sel, a, b));
      checkOutput($sformatf("rndWd%0d", i), WIDTH'(wd_o), WIDTH'(wd_i));
      checkOutput($sformatf("rndWreg%0d", i), WIDTH'(wreg_o), WIDTH'(wreg_i));
    end

    // Randomized divides covering zero, small, large and all-ones divisors.
    for (int i = 0; i < 12; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      runDivide(op, a, b, $sformatf("rndDiv%0d", i));
    end

    applyStimulus(OP_NOP, 3'b000, 32'd0, 32'd0, 1'b0);
    checkOutput("finalWhilo", WIDTH'(whilo_o), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
